// File: rtl/truth_sweep_checker.sv
// truth_sweep_checker: drives all 16 input combinations of a 4-input function
// onto {x,y,w,z}, samples the SoP (s1) and PoS (s2) implementation outputs,
// and compares both against the expected truth table TRUTH.
// Reports the mismatch count, the first failing index and pass/fail.
module truth_sweep_checker #(
    parameter logic [15:0] TRUTH  = 16'hD569,
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       s1,
    input  logic       s2,
    output logic       x,
    output logic       y,
    output logic       w,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail,
    output logic       fail_valid
);

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t     r_state, w_state;
    logic [3:0] r_idx, w_idx;
    logic [3:0] r_settle, w_settle;
    logic [4:0] r_err, w_err;
    logic [3:0] r_first, w_first;
    logic       r_fv, w_fv;
    logic       r_pass, w_pass;
    logic       w_mismatch;

    // Either implementation disagreeing with the table counts as one mismatch.
    assign w_mismatch = (s1 != TRUTH[r_idx]) | (s2 != TRUTH[r_idx]);

    // State and result registers; reset discards any sweep in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_settle <= '0;
            r_err    <= '0;
            r_first  <= '0;
            r_fv     <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_idx    <= w_idx;
            r_settle <= w_settle;
            r_err    <= w_err;
            r_first  <= w_first;
            r_fv     <= w_fv;
            r_pass   <= w_pass;
        end
    end

    // Next-state and result update logic for the sweep sequencer.
    always_comb begin
        w_state  = r_state;
        w_idx    = r_idx;
        w_settle = r_settle;
        w_err    = r_err;
        w_first  = r_first;
        w_fv     = r_fv;
        w_pass   = r_pass;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state  = ST_DRIVE;
                    w_idx    = '0;
                    w_settle = SETTLE_L;
                    w_err    = '0;
                    w_first  = '0;
                    w_fv     = 1'b0;
                    w_pass   = 1'b0;
                end
            end
            ST_DRIVE: begin
                w_settle = r_settle - 4'd1;
                if (r_settle <= 4'd1) begin
                    w_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (w_mismatch) begin
                    w_err = r_err + 5'd1;
                    if (!r_fv) begin
                        w_first = r_idx;
                        w_fv    = 1'b1;
                    end
                end
                if (r_idx == 4'd15) begin
                    // pass must include this final sample, so use the updated count
                    w_state = ST_DONE;
                    w_pass  = (w_err == 5'd0);
                end else begin
                    w_state  = ST_DRIVE;
                    w_idx    = r_idx + 4'd1;
                    w_settle = SETTLE_L;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    // In DONE the index rests at 15, which gives the required 4'b1111 hold.
    assign {x, y, w, z} = r_idx;
    assign busy         = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
    assign done         = (r_state == ST_DONE);
    assign pass         = r_pass;
    assign err_count    = r_err;
    assign first_fail   = r_first;
    assign fail_valid   = r_fv;

endmodule

// File: tb/tb_truth_sweep_checker.sv
// Bench for truth_sweep_checker: two instances (SETTLE=1 and SETTLE=3) each
// drive a modelled function under test whose outputs can be flipped per index.
module tb_truth_sweep_checker;

    localparam logic [15:0] TRUTH = 16'hD569;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start1 = 1'b0;
    logic start3 = 1'b0;
    logic [15:0] flip1_a = '0, flip2_a = '0;
    logic [15:0] flip1_b = '0, flip2_b = '0;
    logic use3 = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instance with SETTLE=1
    logic       x1, y1, w1, z1, busy1, done1, pass1, fv1, s1a, s2a;
    logic [4:0] err1;
    logic [3:0] ff1;
    logic [3:0] idx1;
    assign idx1 = {x1, y1, w1, z1};
    assign s1a  = TRUTH[idx1] ^ flip1_a[idx1];
    assign s2a  = TRUTH[idx1] ^ flip2_a[idx1];

    truth_sweep_checker #(.TRUTH(TRUTH), .SETTLE(1)) dut (
        .clk(clk), .reset(reset), .start(start1), .s1(s1a), .s2(s2a),
        .x(x1), .y(y1), .w(w1), .z(z1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .first_fail(ff1), .fail_valid(fv1)
    );

    // Instance with SETTLE=3
    logic       x3, y3, w3, z3, busy3, done3, pass3, fv3, s1b, s2b;
    logic [4:0] err3;
    logic [3:0] ff3;
    logic [3:0] idx3;
    assign idx3 = {x3, y3, w3, z3};
    assign s1b  = TRUTH[idx3] ^ flip1_b[idx3];
    assign s2b  = TRUTH[idx3] ^ flip2_b[idx3];

    truth_sweep_checker #(.TRUTH(TRUTH), .SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .s1(s1b), .s2(s2b),
        .x(x3), .y(y3), .w(w3), .z(z3), .busy(busy3), .done(done3),
        .pass(pass3), .err_count(err3), .first_fail(ff3), .fail_valid(fv3)
    );

    // Observation mux so one sweep task serves both instances
    logic [3:0] o_idx, o_ff;
    logic [4:0] o_err;
    logic       o_busy, o_done, o_pass, o_fv;
    assign o_idx  = use3 ? idx3  : idx1;
    assign o_ff   = use3 ? ff3   : ff1;
    assign o_err  = use3 ? err3  : err1;
    assign o_busy = use3 ? busy3 : busy1;
    assign o_done = use3 ? done3 : done1;
    assign o_pass = use3 ? pass3 : pass1;
    assign o_fv   = use3 ? fv3   : fv1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) start3 = v;
        else     start1 = v;
    endtask

    // One full sweep with the given output flips; restart_at>=0 re-pulses
    // start mid-sweep, which must be ignored.
    task automatic sweep(input string tag, input bit sel,
                         input logic [15:0] f1, input logic [15:0] f2,
                         input int restart_at);
        int s, total, n, bad, exp_err, exp_ff;
        logic exp_fv;
        logic [15:0] m;
        s     = sel ? 3 : 1;
        total = 16 * (s + 1);
        use3  = sel;
        if (sel) begin flip1_b = f1; flip2_b = f2; end
        else     begin flip1_a = f1; flip2_a = f2; end

        // Expected results straight from the flip pattern
        m       = f1 | f2;
        exp_err = $countones(m);
        exp_fv  = 1'b0;
        exp_ff  = 0;
        for (int i = 0; i < 16; i++) begin
            if (!exp_fv && m[i]) begin
                exp_fv = 1'b1;
                exp_ff = i;
            end
        end

        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        check({tag, " accept"}, 32'({o_busy, o_done, o_err, o_fv, o_ff, o_idx}),
              32'({1'b1, 1'b0, 5'd0, 1'b0, 4'd0, 4'd0}));

        n   = 0;
        bad = 0;
        while (!o_done && n < total + 20) begin
            if (n == restart_at) set_start(sel, 1'b1);
            @(posedge clk);
            #1;
            set_start(sel, 1'b0);
            n++;
            if (n < total) begin
                if (int'(o_idx) != n / (s + 1) || !o_busy) bad++;
            end
        end
        check({tag, " latency"}, 32'(n), 32'(total));
        check({tag, " vector hold"}, 32'(bad), 32'd0);
        check({tag, " done flags"}, 32'({o_done, o_busy, o_pass, o_idx}),
              32'({1'b1, 1'b0, (exp_err == 0), 4'hF}));
        check({tag, " err_count"}, 32'(o_err), 32'(exp_err));
        check({tag, " first_fail"}, 32'({o_fv, o_ff}), 32'({exp_fv, 4'(exp_ff)}));
        repeat (3) @(posedge clk);
        #1;
        check({tag, " results hold"}, 32'({o_done, o_err, o_fv, o_ff}),
              32'({1'b1, 5'(exp_err), exp_fv, 4'(exp_ff)}));
    endtask

    initial begin
        #1;
        check("reset outputs", 32'({idx1, busy1, done1, pass1, err1, ff1, fv1}), 32'd0);
        check("reset outputs3", 32'({idx3, busy3, done3, pass3, err3, ff3, fv3}), 32'd0);
        #20 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle without start", 32'({busy1, done1, idx1}), 32'd0);

        sweep("ideal", 1'b0, 16'h0000, 16'h0000, -1);
        sweep("s1 stuck0", 1'b0, TRUTH, 16'h0000, -1);
        sweep("s2 inv7", 1'b0, 16'h0000, 16'h0080, -1);
        sweep("both9", 1'b0, 16'h0200, 16'h0280, -1);
        sweep("restart ignored", 1'b0, 16'h0000, 16'h0000, 10);

        // Reset in the middle of vector 5
        use3 = 1'b0;
        flip1_a = '0;
        flip2_a = 16'h8001;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("mid-sweep index", 32'({busy1, idx1}), 32'({1'b1, 4'd5}));
        #2 reset = 1'b1;
        #1;
        check("async reset outputs", 32'({idx1, busy1, done1, pass1, err1, ff1, fv1}), 32'd0);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle after reset", 32'({busy1, done1, idx1, err1}), 32'd0);
        sweep("after reset", 1'b0, 16'h0000, 16'h0000, -1);

        for (int k = 0; k < 6; k++) begin
            logic [15:0] r1, r2;
            r1 = 16'($urandom & $urandom & $urandom);
            r2 = 16'($urandom & $urandom & $urandom);
            sweep($sformatf("rand%0d", k), 1'b0, r1, r2, -1);
        end

        sweep("settle3 ideal", 1'b1, 16'h0000, 16'h0000, -1);
        for (int k = 0; k < 2; k++) begin
            logic [15:0] r1, r2;
            r1 = 16'($urandom & $urandom);
            r2 = 16'($urandom & $urandom);
            sweep($sformatf("settle3 rand%0d", k), 1'b1, r1, r2, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
